longframe_gen: RTL and testbench
================================

# longframe_gen

Parametrised multi-channel frame-strobe generator. A single frame counter runs over a programmable period, and each channel drives a strobe of programmable length at a programmable phase within the frame. Continuous and burst (N-frame) modes are supported, as are graceful stop and per-frame reload of timing configuration. It provides the frame/strobe timing source for downstream capture and transmit logic.

## Interface

- WIDTH, 8: width of frame counter and all timing fields.
- CHANNELS, 4: number of independent strobe outputs.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins operation when IDLE.
- stop  in  1  pulse; requests stop at end of current frame.
- cfg_mode  in  1  0 = continuous, 1 = burst.
- cfg_nframes  in  WIDTH  burst length minus one (burst runs cfg_nframes+1 frames).
- cfg_period  in  WIDTH  frame length minus one (P); frame is P+1 cycles.
- cfg_len  in  CHANNELS*WIDTH  strobe length per channel; channel i at [i*WIDTH +: WIDTH].
- cfg_phase  in  CHANNELS*WIDTH  strobe start offset per channel, same packing.
- strb  out  CHANNELS  registered strobes.
- frame_start  out  1  one-cycle pulse marking frame position 0.
- done  out  1  one-cycle pulse when a burst completes or a stop finishes.
- busy  out  1  high in RUN or STOPPING.
- frame_cnt  out  WIDTH  frames completed since start (wraps modulo 2^WIDTH).

## Operation

- States: IDLE, RUN, STOPPING.
- IDLE: cnt held at 0, strb/frame_start low. On start=1 and stop=0: latch all cfg_* into shadow registers, cnt<=0, frame_cnt<=0, go to RUN. start with stop=1 is ignored.
- RUN: cnt increments each cycle; when cnt==P_shadow: cnt<=0, frame_cnt+1, reload cfg_period/cfg_len/cfg_phase shadows (mode and nframes are latched only at start).
- Burst: at the end of a frame (cnt==P) with frame_cnt==nframes_shadow -> IDLE, done pulse.
- stop=1 in RUN -> STOPPING; cnt continues; at cnt==P -> IDLE, done pulse. If stop arrives in the final burst frame, exit is the same single done pulse. stop in STOPPING/IDLE is ignored; start outside IDLE is ignored.
- Channel i position: pos = cnt-ph if cnt>=ph, else cnt+P+1-ph, computed in WIDTH+1 bits. Next strb[i] = active && ph<=P && pos<len.
- Boundaries: len=0 -> channel always low; len>P -> always high while active; ph>P -> always low; P=0 -> 1-cycle frames.
- rst: state IDLE, cnt 0, frame_cnt 0, shadows 0, all outputs 0. Reset mid-frame aborts without done.

## Timing

- Outputs are registered. strb and frame_start in cycle t+1 reflect cnt and state of cycle t.
- start sampled at edge E0: RUN with cnt=0 after E0. frame_start and phase-0 strobes are high after E0+1, i.e. a 2-cycle start-to-strobe latency.
- frame_start is high for exactly one cycle per frame, following each cycle where cnt==0 in RUN/STOPPING.
- done is asserted in the cycle following the final cnt==P, the same cycle state reads IDLE. busy drops in that same cycle.
- strb is low from the cycle after IDLE is entered.
- Config changes during a frame take effect at the next frame boundary, never mid-frame.

## Test plan

- Reset, then start with P=9, len0=3, ph0=0, continuous -> strb[0] high 3 of every 10 cycles, first high at E0+2. frame_start has a period of 10. frame_cnt increments every 10 cycles.
- Wrap: P=9, len1=3, ph1=8 -> strb[1] high at cnt positions 8, 9, 0, contiguous across the frame boundary.
- Burst, nframes=1, P=9 -> exactly 20 RUN cycles, two frame_start pulses, one done pulse, then IDLE with busy=0.
- stop asserted at cnt=4 -> strobes continue through cnt=9, then IDLE with done=1. A second stop in STOPPING and a start in RUN have no effect.
- Change cfg_period 9->4 at cnt=2 -> current frame stays 10 cycles, following frames are 5 cycles. ph=6>P -> that channel stays low. len=0 -> low. len=200 -> constantly high.
- rst asserted at cnt=5 -> next cycle all outputs 0, state IDLE, no done. start afterwards behaves as after power-up.

Source files
------------

// File: rtl/longframe_gen.sv
// Multi-channel frame-strobe generator: one frame counter over a programmable
// period, per-channel strobes at programmable phase/length, burst and stop control.

module longframe_lane #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] len,
  input  logic [WIDTH-1:0] phase,
  input  logic             active,
  output logic             strb_d
);
  logic [WIDTH:0] pos;

  // Position relative to the phase, wrapping across the frame boundary.
  always_comb begin
    if (cnt >= phase) pos = {1'b0, cnt} - {1'b0, phase};
    else              pos = {1'b0, cnt} + {1'b0, period} + (WIDTH+1)'(1) - {1'b0, phase};
    strb_d = active && (phase <= period) && (pos < {1'b0, len});
  end
endmodule

module longframe_gen #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      cfg_mode,
  input  logic [WIDTH-1:0]          cfg_nframes,
  input  logic [WIDTH-1:0]          cfg_period,
  input  logic [CHANNELS*WIDTH-1:0] cfg_len,
  input  logic [CHANNELS*WIDTH-1:0] cfg_phase,
  output logic [CHANNELS-1:0]       strb,
  output logic                      frame_start,
  output logic                      done,
  output logic                      busy,
  output logic [WIDTH-1:0]          frame_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;

  state_e state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [WIDTH-1:0] nframes_q, nframes_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic [CHANNELS-1:0][WIDTH-1:0] len_q, len_d, phase_q, phase_d;
  logic [CHANNELS-1:0] strb_q, strb_d;
  logic frame_start_q, frame_start_d;
  logic done_q, done_d;
  logic active, frame_end;

  assign active    = (state_q != IDLE);
  assign frame_end = active && (cnt_q == period_q);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    longframe_lane #(.WIDTH(WIDTH)) u_lane (
      .cnt    (cnt_q),
      .period (period_q),
      .len    (len_q[i]),
      .phase  (phase_q[i]),
      .active (active),
      .strb_d (strb_d[i])
    );
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_cnt_d   = frame_cnt_q;
    nframes_d     = nframes_q;
    period_d      = period_q;
    mode_d        = mode_q;
    len_d         = len_q;
    phase_d       = phase_q;
    frame_start_d = 1'b0;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !stop) begin
          state_d     = RUN;
          mode_d      = cfg_mode;
          nframes_d   = cfg_nframes;
          period_d    = cfg_period;
          len_d       = cfg_len;
          phase_d     = cfg_phase;
          frame_cnt_d = '0;
        end
      end
      RUN, STOPPING: begin
        frame_start_d = (cnt_q == '0);
        if (frame_end) begin
          cnt_d       = '0;
          frame_cnt_d = frame_cnt_q + 1'b1;
          period_d    = cfg_period;
          len_d       = cfg_len;
          phase_d     = cfg_phase;
          // A stop landing on the last cycle already ends the current frame.
          if (state_q == STOPPING || stop || (mode_q && frame_cnt_q == nframes_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (stop && state_q == RUN) state_d = STOPPING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      frame_cnt_q   <= '0;
      nframes_q     <= '0;
      period_q      <= '0;
      mode_q        <= 1'b0;
      len_q         <= '0;
      phase_q       <= '0;
      strb_q        <= '0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      nframes_q     <= nframes_d;
      period_q      <= period_d;
      mode_q        <= mode_d;
      len_q         <= len_d;
      phase_q       <= phase_d;
      strb_q        <= strb_d;
      frame_start_q <= frame_start_d;
      done_q        <= done_d;
    end
  end

  assign strb        = strb_q;
  assign frame_start = frame_start_q;
  assign done        = done_q;
  assign busy        = active;
  assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_longframe_gen.sv
// Bench for longframe_gen: outputs compared per cycle against a frame-list model
// that derives strobes from modular frame positions.

module tb_longframe_gen;
  localparam int W  = 8;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst, start, stop, cfg_mode;
  logic [W-1:0] cfg_nframes, cfg_period;
  logic [CH*W-1:0] cfg_len, cfg_phase;
  logic [CH-1:0] strb;
  logic frame_start, done, busy;
  logic [W-1:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: periods of the frames the run will execute, plus constant lane config.
  int m_per[$];
  int m_len[CH];
  int m_ph[CH];

  longframe_gen #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_mode(cfg_mode),
    .cfg_nframes(cfg_nframes), .cfg_period(cfg_period), .cfg_len(cfg_len),
    .cfg_phase(cfg_phase), .strb(strb), .frame_start(frame_start), .done(done),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs();
    return {frame_cnt, busy, done, frame_start, strb};
  endfunction

  function automatic int total_t();
    int s = 0;
    foreach (m_per[f]) s += m_per[f] + 1;
    return s;
  endfunction

  // Expected outputs observed k cycles after the start edge (reflecting cycle k-1).
  function automatic logic [15:0] exp_vec(int k);
    int t, s, fd, c, L;
    logic [CH-1:0] st;
    logic fs;
    t = k - 1; s = 0; fd = 0; st = '0; fs = 1'b0;
    foreach (m_per[f]) begin
      L = m_per[f] + 1;
      if (t >= s && t < s + L) begin
        c  = t - s;
        fs = (c == 0);
        for (int i = 0; i < CH; i++)
          if (m_ph[i] <= m_per[f])
            if (((c - m_ph[i] + L) % L) < m_len[i]) st[i] = 1'b1;
      end
      if (s + L <= k) fd++;
      s += L;
    end
    return {8'(fd), (k < s), (k == s), fs, st};
  endfunction

  task automatic apply_lanes();
    for (int i = 0; i < CH; i++) begin
      cfg_len[i*W +: W]   = 8'(m_len[i]);
      cfg_phase[i*W +: W] = 8'(m_ph[i]);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; stop = 0; cfg_mode = 0; cfg_nframes = 0; cfg_period = 0;
    cfg_len = '0; cfg_phase = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs() !== 16'h0) begin
      n_fail++; $display("FAIL reset_state got=%h exp=%h", obs(), 16'h0);
    end
    rst = 1'b0;
    cfg_period = 8'd9; m_len = '{3, 3, 3, 3}; m_ph = '{0, 0, 0, 0}; apply_lanes();
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (2) begin
      n_checks++;
      if (obs() !== 16'h0) begin
        n_fail++; $display("FAIL start_with_stop got=%h exp=%h", obs(), 16'h0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_continuous();
    int s_at;
    cfg_mode = 1'b0; cfg_period = 8'd9;
    m_len = '{3, 3, $urandom_range(0, 12), $urandom_range(0, 12)};
    m_ph  = '{0, 8, $urandom_range(0, 11), $urandom_range(0, 11)};
    apply_lanes();
    m_per = '{9, 9, 9, 9};
    s_at  = 30 + $urandom_range(0, 9);
    do_start();
    for (int k = 0; k <= total_t() + 2; k++) begin
      n_checks++;
      if (obs() !== exp_vec(k)) begin
        n_fail++; $display("FAIL continuous k=%0d got=%h exp=%h", k, obs(), exp_vec(k));
      end
      stop = (k == s_at);
      @(negedge clk);
    end
    stop = 1'b0;
  endtask

  task automatic test_stop();
    cfg_mode = 1'b0; cfg_period = 8'd9;
    m_len = '{2, 4, 10, $urandom_range(0, 11)};
    m_ph  = '{3, 7, 0, $urandom_range(0, 9)};
    apply_lanes();
    m_per = '{9, 9};
    do_start();
    for (int k = 0; k <= total_t() + 2; k++) begin
      n_checks++;
      if (obs() !== exp_vec(k)) begin
        n_fail++; $display("FAIL stop k=%0d got=%h exp=%h", k, obs(), exp_vec(k));
      end
      start = (k == 7 || k == 17);
      stop  = (k == 14 || k == 16);
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_burst();
    int n_fs, n_done, n_busy;
    n_fs = 0; n_done = 0; n_busy = 0;
    cfg_mode = 1'b1; cfg_nframes = 8'd1; cfg_period = 8'd9;
    for (int i = 0; i < CH; i++) begin
      m_len[i] = $urandom_range(0, 11);
      m_ph[i]  = $urandom_range(0, 10);
    end
    apply_lanes();
    m_per = '{9, 9};
    do_start();
    for (int k = 0; k <= total_t() + 2; k++) begin
      n_checks++;
      if (obs() !== exp_vec(k)) begin
        n_fail++; $display("FAIL burst k=%0d got=%h exp=%h", k, obs(), exp_vec(k));
      end
      n_fs += int'(frame_start); n_done += int'(done); n_busy += int'(busy);
      @(negedge clk);
    end
    n_checks += 3;
    if (n_fs !== 2)    begin n_fail++; $display("FAIL burst_fs_count got=%0d exp=2", n_fs); end
    if (n_done !== 1)  begin n_fail++; $display("FAIL burst_done_count got=%0d exp=1", n_done); end
    if (n_busy !== 20) begin n_fail++; $display("FAIL burst_busy_cycles got=%0d exp=20", n_busy); end
  endtask

  task automatic test_period_change();
    cfg_mode = 1'b0; cfg_period = 8'd9;
    m_len = '{2, 0, 200, $urandom_range(0, 5)};
    m_ph  = '{6, 0, 0, $urandom_range(0, 4)};
    apply_lanes();
    m_per = '{9, 4, 4};
    do_start();
    for (int k = 0; k <= total_t() + 2; k++) begin
      n_checks++;
      if (obs() !== exp_vec(k)) begin
        n_fail++; $display("FAIL period_change k=%0d got=%h exp=%h", k, obs(), exp_vec(k));
      end
      if (k == 2) cfg_period = 8'd4;
      stop = (k == 17);
      @(negedge clk);
    end
    stop = 1'b0;
  endtask

  task automatic test_p0();
    cfg_mode = 1'b1; cfg_nframes = 8'd3; cfg_period = 8'd0;
    m_len = '{1, 1, 0, 5};
    m_ph  = '{0, 1, 0, 0};
    apply_lanes();
    m_per = '{0, 0, 0, 0};
    do_start();
    for (int k = 0; k <= total_t() + 2; k++) begin
      n_checks++;
      if (obs() !== exp_vec(k)) begin
        n_fail++; $display("FAIL p0 k=%0d got=%h exp=%h", k, obs(), exp_vec(k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random_burst();
    int p, nfr;
    for (int r = 0; r < 4; r++) begin
      p = $urandom_range(1, 15); nfr = $urandom_range(1, 3);
      cfg_mode = 1'b1; cfg_nframes = 8'(nfr - 1); cfg_period = 8'(p);
      for (int i = 0; i < CH; i++) begin
        m_len[i] = $urandom_range(0, p + 2);
        m_ph[i]  = $urandom_range(0, p + 1);
      end
      apply_lanes();
      m_per = {};
      for (int f = 0; f < nfr; f++) m_per.push_back(p);
      do_start();
      for (int k = 0; k <= total_t() + 2; k++) begin
        n_checks++;
        if (obs() !== exp_vec(k)) begin
          n_fail++; $display("FAIL random_burst r=%0d k=%0d got=%h exp=%h", r, k, obs(), exp_vec(k));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid();
    cfg_mode = 1'b0; cfg_period = 8'd9;
    m_len = '{3, 5, 10, 1}; m_ph = '{0, 2, 0, 4};
    apply_lanes();
    m_per = '{9};
    do_start();
    for (int k = 0; k <= 5; k++) begin
      n_checks++;
      if (obs() !== exp_vec(k)) begin
        n_fail++; $display("FAIL reset_mid_pre k=%0d got=%h exp=%h", k, obs(), exp_vec(k));
      end
      if (k < 5) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      n_checks++;
      if (obs() !== 16'h0) begin
        n_fail++; $display("FAIL reset_mid got=%h exp=%h", obs(), 16'h0);
      end
      @(negedge clk);
    end
    m_per = '{9, 9};
    do_start();
    for (int k = 0; k <= total_t() + 2; k++) begin
      n_checks++;
      if (obs() !== exp_vec(k)) begin
        n_fail++; $display("FAIL after_reset k=%0d got=%h exp=%h", k, obs(), exp_vec(k));
      end
      stop = (k == 12);
      @(negedge clk);
    end
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_stop();
    test_burst();
    test_period_change();
    test_p0();
    test_random_burst();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
